// File: rtl/vga_capture_decoder.sv
// VGA timing sink. Samples hSync/vSync/rgb on the pixel strobe, recovers the
// x/y position of each sample, checks line and frame lengths, and streams the
// active pixels of locked frames out as frame-buffer writes.
//
// Handshake: there is no back-pressure. Each clk with wEn=1 carries exactly
// one write {addr, dataOut}; the consumer must accept it in that clk.
// addr and dataOut keep their last value while wEn=0.
module vga_capture_decoder #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int H_TOTAL        = 800,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int V_TOTAL        = 525,
    parameter int LOCK_FRAMES    = 2,
    parameter int BITS_PER_COLOR = 12,
    parameter int ADDRESS_WIDTH  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pixEn,
    input  logic                      hSync,
    input  logic                      vSync,
    input  logic [BITS_PER_COLOR-1:0] rgb,
    output logic                      wEn,
    output logic [ADDRESS_WIDTH-1:0]  addr,
    output logic [BITS_PER_COLOR-1:0] dataOut,
    output logic                      locked,
    output logic                      frameStart,
    output logic [7:0]                errCount
);

    localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] H_OFF     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + WIDTH);
    localparam logic [10:0] V_OFF     = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + HEIGHT);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;
    localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [GOOD_W-1:0]   good;
    logic [GOOD_W-1:0]   good_next;
    logic [GOOD_W-1:0]   good_inc;

    logic                prev_h;
    logic                prev_v;
    logic [9:0]          h_cnt;
    logic [9:0]          v_cnt;
    logic [9:0]          h_next;
    logic [9:0]          v_next;

    logic                h_edge;
    logic                v_start;
    logic                line_bad;
    logic                frame_bad;
    logic                timing_bad;
    logic                active;
    logic [9:0]          x;
    logic [8:0]          y;
    logic [ADDRESS_WIDTH-1:0] pixel_addr;

    logic                err_inc;
    logic                wr_next;
    logic                frame_start_next;

    // Sync edge detection and the position the current sample will occupy.
    always_comb begin
        h_edge  = pixEn & prev_h & ~hSync;
        v_start = h_edge & ~vSync & prev_v;

        h_next = h_cnt;
        if (h_edge) begin
            h_next = 10'd0;
        end else if (h_cnt != CNT_MAX) begin
            h_next = h_cnt + 10'd1;
        end

        v_next = v_cnt;
        if (v_start) begin
            v_next = 10'd0;
        end else if (h_edge && (v_cnt != CNT_MAX)) begin
            v_next = v_cnt + 10'd1;
        end

        // The old count is the index of the last sample of the closing line/frame.
        line_bad   = h_edge  && (({1'b0, h_cnt} + 11'd1) != H_TOTAL_C);
        frame_bad  = v_start && (({1'b0, v_cnt} + 11'd1) != V_TOTAL_C);
        timing_bad = line_bad | frame_bad;

        active = ({1'b0, h_next} >= H_OFF) && ({1'b0, h_next} < H_END) &&
                 ({1'b0, v_next} >= V_OFF) && ({1'b0, v_next} < V_END);
        x = h_next - H_OFF[9:0];
        y = v_next[8:0] - V_OFF[8:0];
        pixel_addr = ADDRESS_WIDTH'(x) + ADDRESS_WIDTH'(y) * ADDRESS_WIDTH'(WIDTH);
    end

    // Lock FSM: next state, good-frame count, error strobe and output requests.
    always_comb begin
        state_next       = state;
        good_next        = good;
        good_inc         = good + GOOD_W'(1);
        err_inc          = 1'b0;
        wr_next          = 1'b0;
        frame_start_next = 1'b0;

        if (pixEn) begin
            case (state)
                SEARCH: begin
                    if (v_start) begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end
                end
                ACQUIRE: begin
                    if (timing_bad) begin
                        state_next = SEARCH;
                        err_inc    = 1'b1;
                    end else if (v_start) begin
                        good_next = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (timing_bad) begin
                        state_next = SEARCH;
                        err_inc    = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase

            wr_next          = active && (state == LOCKED);
            frame_start_next = v_start && (state_next == LOCKED);
        end
    end

    // FSM state and good-frame counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    // Sync history and x/y counters advance only on the pixel strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_h <= 1'b1;
            prev_v <= 1'b1;
            h_cnt  <= 10'd0;
            v_cnt  <= 10'd0;
        end else if (pixEn) begin
            prev_h <= hSync;
            h_cnt  <= h_next;
            v_cnt  <= v_next;
            if (h_edge) begin
                prev_v <= vSync;
            end
        end
    end

    // Registered write port, frame pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wEn        <= 1'b0;
            addr       <= '0;
            dataOut    <= '0;
            frameStart <= 1'b0;
            errCount   <= 8'd0;
        end else begin
            wEn        <= wr_next;
            frameStart <= frame_start_next;
            if (wr_next) begin
                addr    <= pixel_addr;
                dataOut <= rgb;
            end
            if (err_inc && (errCount != 8'hFF)) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_capture_decoder.sv
// Bench for vga_capture_decoder using a scaled-down raster (8x4 active,
// 16x9 total) so that many frames fit in a short run. A source model drives
// the sync/rgb pattern; a write monitor checks every wEn against an expected
// queue filled by the source for frames that must be captured.
module tb_vga_capture_decoder;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int HS   = 2;
    localparam int HB   = 2;
    localparam int HT   = 16;
    localparam int VS   = 2;
    localparam int VB   = 1;
    localparam int VT   = 9;
    localparam int LF   = 2;
    localparam int AW   = 20;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB;
    localparam int ALL  = 1000;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          pixEn  = 1'b0;
    logic          hSync  = 1'b1;
    logic          vSync  = 1'b1;
    logic [11:0]   rgb    = 12'h000;
    logic          wEn;
    logic [AW-1:0] addr;
    logic [11:0]   dataOut;
    logic          locked;
    logic          frameStart;
    logic [7:0]    errCount;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+11:0] exp_q[$];
    int             wr_count = 0;
    int             fs_count = 0;
    logic           pix_last = 1'b0;
    logic           fs_seen  = 1'b0;
    logic [AW-1:0]  first_addr = '1;
    logic [11:0]    first_data = '1;
    int             gap_mode = 0;

    vga_capture_decoder #(
        .WIDTH(W), .HEIGHT(H), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(LF),
        .BITS_PER_COLOR(12), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .pixEn(pixEn), .hSync(hSync), .vSync(vSync),
        .rgb(rgb), .wEn(wEn), .addr(addr), .dataOut(dataOut), .locked(locked),
        .frameStart(frameStart), .errCount(errCount)
    );

    // Clock
    always #5 clk = ~clk;

    // Strobe seen by the DUT at the latest rising edge.
    always @(posedge clk) pix_last <= pixEn;

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        logic [AW+11:0] exp;
        if (wEn) begin
            wr_count++;
            n_checks++;
            if (pix_last !== 1'b1) begin
                n_errors++;
                $display("FAIL wen_after_strobe: wEn=1 with previous pixEn=%b, required 1", pix_last);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", addr, dataOut);
            end else begin
                exp = exp_q.pop_front();
                if ({addr, dataOut} !== exp) begin
                    n_errors++;
                    $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr, dataOut, exp[AW+11:12], exp[11:0]);
                end
            end
            if (fs_seen) begin
                first_addr = addr;
                first_data = dataOut;
                fs_seen    = 1'b0;
            end
        end
        if (frameStart) begin
            fs_count++;
            fs_seen = 1'b1;
            n_checks++;
            if (locked !== 1'b1) begin
                n_errors++;
                $display("FAIL fs_locked: frameStart with locked=%b, required 1", locked);
            end
        end
    end

    // Watchdog
    initial begin
        #1ms;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] rgb_of(input int px, input int py);
        if (px == 0 && py == 0) return 12'hF00;
        if (px == W - 1 && py == H - 1) return 12'h0AB;
        return {4'h5, 4'(px), 4'(py)};
    endfunction

    // One pixel: strobe for one clk, then idle until the next strobe slot.
    task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] color);
        int gap;
        gap   = (gap_mode != 0) ? int'($urandom_range(3, 7)) : 4;
        hSync = hs;
        vSync = vs;
        rgb   = color;
        pixEn = 1'b1;
        @(negedge clk);
        pixEn = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // One frame; long_line gets an extra pixel, lines up to write_last are
    // expected to be captured, stop_line ends the frame half-way through it.
    task automatic send_frame(input int n_lines, input int long_line,
                              input int write_last, input int stop_line);
        int  len;
        bit  act;
        logic [11:0] color;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            for (int p = 0; p < len; p++) begin
                if (l == stop_line && p == HOFF + W / 2) return;
                act = (p >= HOFF) && (p < HOFF + W) && (l >= VOFF) && (l < VOFF + H);
                color = act ? rgb_of(p - HOFF, l - VOFF) : 12'hABC;
                if (act && l <= write_last)
                    exp_q.push_back({AW'((p - HOFF) + W * (l - VOFF)), color});
                send_pixel((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, color);
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (wEn !== 1'b0) begin n_errors++; $display("FAIL reset_wen: got %b required 0", wEn); end
        if (addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %0d required 0", addr); end
        if (dataOut !== 12'h000) begin n_errors++; $display("FAIL reset_data: got %h required 000", dataOut); end
        if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b required 0", locked); end
        if (frameStart !== 1'b0) begin n_errors++; $display("FAIL reset_fs: got %b required 0", frameStart); end
        if (errCount !== 8'd0) begin n_errors++; $display("FAIL reset_err: got %0d required 0", errCount); end
        reset = 1'b0;
    endtask

    task automatic test_lock_ideal();
        int wr0 = wr_count;
        int fs0 = fs_count;
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %b required 0", locked); end
        send_frame(VT, -1, ALL, -1);
        n_checks += 2;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_third: got %b required 1", locked); end
        if (wr_count - wr0 != W * H) begin n_errors++; $display("FAIL lock_wr_frame: got %0d required %0d", wr_count - wr0, W * H); end
        send_frame(VT, -1, ALL, -1);
        n_checks += 4;
        if (wr_count - wr0 != 2 * W * H) begin n_errors++; $display("FAIL lock_wr_total: got %0d required %0d", wr_count - wr0, 2 * W * H); end
        if (fs_count - fs0 != 2) begin n_errors++; $display("FAIL lock_fs: got %0d required 2", fs_count - fs0); end
        if (errCount !== 8'd0) begin n_errors++; $display("FAIL lock_err: got %0d required 0", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL lock_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_corner_pixels();
        send_frame(VT, -1, ALL, -1);
        n_checks += 6;
        if (first_addr !== AW'(0)) begin n_errors++; $display("FAIL corner_first_addr: got %0d required 0", first_addr); end
        if (first_data !== 12'hF00) begin n_errors++; $display("FAIL corner_first_data: got %h required F00", first_data); end
        if (wEn !== 1'b0) begin n_errors++; $display("FAIL corner_idle_wen: got %b required 0", wEn); end
        if (addr !== AW'(W * H - 1)) begin n_errors++; $display("FAIL corner_last_addr: got %0d required %0d", addr, W * H - 1); end
        if (dataOut !== 12'h0AB) begin n_errors++; $display("FAIL corner_last_data: got %h required 0AB", dataOut); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL corner_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_bad_line();
        send_frame(VT, VOFF + 1, VOFF + 1, -1);
        n_checks += 3;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL badline_unlock: got %b required 0", locked); end
        if (errCount !== 8'd1) begin n_errors++; $display("FAIL badline_err: got %0d required 1", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL badline_missing: got %0d pending required 0", exp_q.size()); end
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL badline_early: got %b required 0", locked); end
        send_frame(VT, -1, ALL, -1);
        n_checks += 3;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL badline_relock: got %b required 1", locked); end
        if (errCount !== 8'd1) begin n_errors++; $display("FAIL badline_err_hold: got %0d required 1", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL badline_relock_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_short_frame();
        pulse_reset();
        send_frame(VT, -1, -1, -1);
        send_frame(VT - 1, -1, -1, -1);
        n_checks += 2;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL short_acq_locked: got %b required 0", locked); end
        if (errCount !== 8'd0) begin n_errors++; $display("FAIL short_acq_err: got %0d required 0", errCount); end
        send_frame(VT, -1, -1, -1);
        n_checks += 2;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL short_locked: got %b required 0", locked); end
        if (errCount !== 8'd1) begin n_errors++; $display("FAIL short_err: got %0d required 1", errCount); end
    endtask

    task automatic test_irregular_pixen();
        int wr0;
        int fs0;
        gap_mode = 1;
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        wr0 = wr_count;
        fs0 = fs_count;
        send_frame(VT, -1, ALL, -1);
        send_frame(VT, -1, ALL, -1);
        gap_mode = 0;
        n_checks += 5;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL irr_locked: got %b required 1", locked); end
        if (wr_count - wr0 != 2 * W * H) begin n_errors++; $display("FAIL irr_wr_count: got %0d required %0d", wr_count - wr0, 2 * W * H); end
        if (fs_count - fs0 != 2) begin n_errors++; $display("FAIL irr_fs: got %0d required 2", fs_count - fs0); end
        if (errCount !== 8'd1) begin n_errors++; $display("FAIL irr_err: got %0d required 1", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL irr_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_line();
        send_frame(VT, -1, ALL, VOFF + 1);
        pulse_reset();
        n_checks += 7;
        if (wEn !== 1'b0) begin n_errors++; $display("FAIL midrst_wen: got %b required 0", wEn); end
        if (addr !== '0) begin n_errors++; $display("FAIL midrst_addr: got %0d required 0", addr); end
        if (dataOut !== 12'h000) begin n_errors++; $display("FAIL midrst_data: got %h required 000", dataOut); end
        if (locked !== 1'b0) begin n_errors++; $display("FAIL midrst_locked: got %b required 0", locked); end
        if (frameStart !== 1'b0) begin n_errors++; $display("FAIL midrst_fs: got %b required 0", frameStart); end
        if (errCount !== 8'd0) begin n_errors++; $display("FAIL midrst_err: got %0d required 0", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL midrst_missing: got %0d pending required 0", exp_q.size()); end
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL midrst_early: got %b required 0", locked); end
        send_frame(VT, -1, ALL, -1);
        n_checks += 3;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL midrst_relock: got %b required 1", locked); end
        if (errCount !== 8'd0) begin n_errors++; $display("FAIL midrst_err_after: got %0d required 0", errCount); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL midrst_relock_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lock_ideal();
        test_corner_pixels();
        test_bad_line();
        test_short_frame();
        test_irregular_pixen();
        test_reset_mid_line();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
